instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 113 +++++++++++
 tb/tb_instruction_fetch.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch: single-outstanding imem read FSM with redirect, drop and halt handling.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect targets halt fetch and set a sticky flag.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_target,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instruction,
  output logic [63:0] out_pc,
  output logic        halted,
  output logic        misaligned
);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DROP, OUT, HALT} state_t;

  state_t      r_state, w_state_next;
  logic [63:0] r_pc, w_pc_next;
  logic [31:0] r_instr, w_instr_next;
  logic [63:0] r_out_pc, w_out_pc_next;
  logic        r_misaligned, w_misaligned_next;
  logic [63:0] w_target;
  logic        w_bad_target;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_target     = redirect_target;
  assign w_bad_target = |redirect_target[1:0];
`else
  assign w_target     = redirect_target & 64'hFFFF_FFFF_FFFF_FFFC;
  assign w_bad_target = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_instr      <= '0;
      r_out_pc     <= '0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_pc         <= w_pc_next;
      r_instr      <= w_instr_next;
      r_out_pc     <= w_out_pc_next;
      r_misaligned <= w_misaligned_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_instr_next      = r_instr;
    w_out_pc_next     = r_out_pc;
    w_misaligned_next = r_misaligned;
    // A bad target halts from any redirect-accepting state; pc keeps its old value.
    if (r_state != HALT && redirect_valid && w_bad_target) begin
      w_misaligned_next = 1'b1;
      w_state_next      = HALT;
    end else begin
      case (r_state)
        IDLE, REQ: begin
          w_state_next = (r_state == IDLE) ? REQ : WAIT;
          if (redirect_valid) begin
            w_pc_next    = w_target;
            w_state_next = REQ;
          end
        end
        WAIT: begin
          if (redirect_valid) begin
            w_pc_next    = w_target;
            w_state_next = imem_rvalid ? REQ : DROP;
          end else if (imem_rvalid) begin
            w_instr_next  = imem_rdata;
            w_out_pc_next = r_pc;
            w_state_next  = (imem_rdata == HALT_WORD) ? HALT : OUT;
          end
        end
        DROP: begin
          if (redirect_valid) w_pc_next = w_target;
          // Leave once the stale response is consumed, even if a redirect arrives with it.
          if (imem_rvalid) w_state_next = REQ;
        end
        OUT: begin
          if (redirect_valid) begin
            w_pc_next    = w_target;
            w_state_next = REQ;
          end else if (out_ready) begin
            w_pc_next    = r_pc + 64'd4;
            w_state_next = REQ;
          end
        end
        default: w_state_next = HALT;
      endcase
    end
  end

  assign imem_req        = (r_state == REQ);
  assign imem_addr       = imem_req ? r_pc : '0;
  assign out_valid       = (r_state == OUT);
  assign out_instruction = r_instr;
  assign out_pc          = r_out_pc;
  assign halted          = (r_state == HALT);
  assign misaligned      = r_misaligned;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch with a fixed-latency memory responder.
// Cycle n = the clock period following the n-th edge, counting the last reset-high edge as 1.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_target = '0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instruction;
  logic [63:0] out_pc;
  logic        halted;
  logic        misaligned;

  int checks = 0;
  int errors = 0;
  int lat = 1;
  int cnt = 0;
  logic [63:0] addr_q = '0;

  instruction_fetch #(.RESET_PC(64'h0), .HALT_WORD(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instruction(out_instruction), .out_pc(out_pc),
    .halted(halted), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h0050_0093;
      64'h4:   return 32'h0010_0113;
      64'h8:   return 32'h0020_0193;
      64'h100: return 32'h0030_0213;
      64'h200: return 32'h0040_0293;
      64'h204: return 32'hDEAD_0013;
      64'h300: return 32'h0000_0000;
      default: return 32'h0000_0013;
    endcase
  endfunction

  // Memory model: answers each request `lat` cycles later; not cleared by DUT reset.
  always @(posedge clk) begin
    imem_rvalid <= 1'b0;
    if (cnt != 0) begin
      if (cnt == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(addr_q);
      end
      cnt <= cnt - 1;
    end else if (imem_req) begin
      if (lat == 1) begin
        imem_rvalid <= 1'b1;
        imem_rdata  <= mem_word(imem_addr);
      end else begin
        cnt    <= lat - 1;
        addr_q <= imem_addr;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_addr"}, imem_addr, 64'h0);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_instr"}, out_instruction, 32'h0);
    check({tag, "_pc"}, out_pc, 64'h0);
    check({tag, "_halted"}, halted, 1'b0);
    check({tag, "_misal"}, misaligned, 1'b0);
  endtask

  initial begin
    // Reset and first fetch
    reset = 1'b1;
    step(); step();
    check_reset_state("rst");
    reset = 1'b0;                      // cycle 1: IDLE
    step();                            // cycle 2: REQ
    check("c2_req", imem_req, 1'b1);
    check("c2_addr", imem_addr, 64'h0);
    step();                            // cycle 3: WAIT
    check("c3_req", imem_req, 1'b0);
    check("c3_valid", out_valid, 1'b0);
    step();                            // cycle 4: OUT
    check("c4_valid", out_valid, 1'b1);
    check("c4_instr", out_instruction, 32'h0050_0093);
    check("c4_pc", out_pc, 64'h0);

    // Backpressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_valid", out_valid, 1'b1);
      check("stall_instr", out_instruction, 32'h0050_0093);
      check("stall_pc", out_pc, 64'h0);
      check("stall_req", imem_req, 1'b0);
    end
    out_ready = 1'b1;
    step();
    check("acc_req", imem_req, 1'b1);
    check("acc_addr", imem_addr, 64'h4);
    out_ready = 1'b0;
    step(); step();
    check("pc4_valid", out_valid, 1'b1);
    check("pc4_instr", out_instruction, 32'h0010_0113);
    check("pc4_pc", out_pc, 64'h4);
    out_ready = 1'b1;
    step();
    check("pc8_addr", imem_addr, 64'h8);
    out_ready = 1'b0;
    step(); step();
    check("pc8_pc", out_pc, 64'h8);
    check("pc8_instr", out_instruction, 32'h0020_0193);

    // Redirect beats a simultaneous accept
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 64'h200;
    step();
    check("redir_acc_req", imem_req, 1'b1);
    check("redir_acc_addr", imem_addr, 64'h200);
    out_ready = 1'b0; redirect_valid = 1'b0;
    step(); step();
    check("r200_pc", out_pc, 64'h200);
    check("r200_instr", out_instruction, 32'h0040_0293);

    // Redirect in WAIT with a late response: stale word must be dropped
    out_ready = 1'b1;
    step();
    check("p204_addr", imem_addr, 64'h204);
    out_ready = 1'b0; lat = 3;
    step();                            // WAIT
    redirect_valid = 1'b1; redirect_target = 64'h100;
    step();                            // DROP
    redirect_valid = 1'b0;
    check("drop_req", imem_req, 1'b0);
    check("drop_valid", out_valid, 1'b0);
    step();                            // DROP, stale response visible
    check("drop2_req", imem_req, 1'b0);
    check("drop2_valid", out_valid, 1'b0);
    step();
    check("r100_req", imem_req, 1'b1);
    check("r100_addr", imem_addr, 64'h100);
    lat = 1;
    step(); step();
    check("r100_valid", out_valid, 1'b1);
    check("r100_pc", out_pc, 64'h100);
    check("r100_instr", out_instruction, 32'h0030_0213);

    // Misaligned redirect target
    redirect_valid = 1'b1; redirect_target = 64'h102;
    step();
    redirect_valid = 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
    check("mis_flag", misaligned, 1'b1);
    check("mis_halt", halted, 1'b1);
    check("mis_req", imem_req, 1'b0);
`else
    check("mis_flag", misaligned, 1'b0);
    check("mis_req", imem_req, 1'b1);
    check("mis_addr", imem_addr, 64'h100);
`endif

    // Reset from any state; then reset while a response is outstanding
    reset = 1'b1;
    step(); step();
    check_reset_state("rst2");
    reset = 1'b0;
    step();
    check("rst2_req", imem_req, 1'b1);
    lat = 3;
    step();                            // WAIT, response 2 edges away
    reset = 1'b1;
    step(); step();
    reset = 1'b0;                      // IDLE while stale response is visible
    check("rst3_req", imem_req, 1'b0);
    check("rst3_valid", out_valid, 1'b0);
    step();
    check("rst3_req2", imem_req, 1'b1);
    check("rst3_addr", imem_addr, 64'h0);
    lat = 1;
    step(); step();
    check("rst3_valid2", out_valid, 1'b1);
    check("rst3_instr", out_instruction, 32'h0050_0093);
    check("rst3_pc", out_pc, 64'h0);

    // PC wrap at the top of the address space
    redirect_valid = 1'b1; redirect_target = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("top_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(); step();
    check("top_pc", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    check("top_instr", out_instruction, 32'h0000_0013);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("wrap_req", imem_req, 1'b1);
    check("wrap_addr", imem_addr, 64'h0);
    step(); step();
    check("wrap_instr", out_instruction, 32'h0050_0093);

    // Halt word stops fetch for good
    redirect_valid = 1'b1; redirect_target = 64'h300;
    step();
    redirect_valid = 1'b0;
    check("h_addr", imem_addr, 64'h300);
    step(); step();
    check("h_halted", halted, 1'b1);
    check("h_valid", out_valid, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      redirect_valid = i[0];
      redirect_target = 64'h100;
      step();
      check("h_noreq", imem_req, 1'b0);
      check("h_stay", halted, 1'b1);
    end
    redirect_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    step(); step();
    check_reset_state("rst4");
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
